spawn_scheduler: RTL and testbench



---
 rtl/spawn_scheduler.sv | 168 ++++++++++++++++
 tb/tb_spawn_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spawn_scheduler.sv
// Player-side deploy controller: owns the elixir pool, arbitrates unit deploy
// requests round-robin and turns each grant into a frame-aligned spawn level.
module spawn_scheduler #(
  parameter int unsigned ELIXIR_MAX        = 10,
  parameter int unsigned ELIXIR_INIT       = 5,
  parameter int unsigned FRAMES_PER_ELIXIR = 60,
  parameter int unsigned COST_AND          = 3,
  parameter int unsigned COST_OR           = 3,
  parameter int unsigned COST_NOT          = 2,
  parameter int unsigned COST_NERD         = 5,
  parameter int unsigned COOLDOWN_FRAMES   = 30
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       game_over,
  input  logic [3:0] req_valid,
  input  logic [3:0] req_lane,
  input  logic [3:0] unit_busy,
  output logic [3:0] spawn_left,
  output logic [3:0] spawn_right,
  output logic [3:0] req_ack,
  output logic [3:0] elixir,
  output logic       busy,
  output logic [1:0] dbg_state
);

  localparam int unsigned FC_W = (FRAMES_PER_ELIXIR > 1) ? $clog2(FRAMES_PER_ELIXIR) : 1;
  localparam int unsigned CD_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_ELIXIR - 1);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);
  localparam logic [3:0] E_MAX  = 4'(ELIXIR_MAX);
  localparam logic [3:0] E_INIT = 4'(ELIXIR_INIT);
  localparam logic CD_NONE = (COOLDOWN_FRAMES == 0);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, COOLDOWN = 2'd2} state_t;

  function automatic logic [3:0] cost_of(input logic [1:0] u);
    case (u)
      2'd0:    return 4'(COST_AND);
      2'd1:    return 4'(COST_OR);
      2'd2:    return 4'(COST_NOT);
      default: return 4'(COST_NERD);
    endcase
  endfunction

  state_t          state, state_nx;
  logic            vsync_q, tick;
  logic [FC_W-1:0] frame_cnt;
  logic [CD_W-1:0] cd_cnt, cd_nx;
  logic [1:0]      last_grant, last_nx, id_q, id_nx, win_id;
  logic            lane_q, lane_nx, win_found, grant;
  logic [3:0]      eligible, elixir_nx, spawn_left_nx, spawn_right_nx;
  logic            regen_step, regen_inc;
  logic [4:0]      elixir_sum;

  // vsync is already in the vga_clk domain, so one register suffices for the edge.
  always_ff @(posedge vga_clk) vsync_q <= vsync;
  assign tick = vsync & ~vsync_q;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      eligible[i] = req_valid[i] & ~unit_busy[i] & (elixir >= cost_of(2'(i))) & ~game_over;
    end
  end

  // Scan starts just after the last winner so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_id    = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      if (!win_found && eligible[2'(last_grant + 2'(k))]) begin
        win_found = 1'b1;
        win_id    = 2'(last_grant + 2'(k));
      end
    end
  end

  // Handshake: req_valid is a level the unit holds while it wants to deploy;
  // the request is accepted in the single cycle its req_ack bit is high.
  assign grant   = (state == IDLE) & tick & win_found & ~reset;
  assign req_ack = grant ? (4'b0001 << win_id) : 4'b0000;

  assign regen_step = tick & ~game_over & (elixir < E_MAX);
  assign regen_inc  = regen_step & (frame_cnt == FC_LAST);

  // Cost comes off the pre-regen value, then the same-tick regen is added back.
  always_comb begin
    elixir_sum = {1'b0, elixir};
    if (grant) elixir_sum = elixir_sum - {1'b0, cost_of(win_id)};
    elixir_sum = elixir_sum + 5'(regen_inc);
    if (elixir_sum > {1'b0, E_MAX}) elixir_sum = {1'b0, E_MAX};
  end
  assign elixir_nx = elixir_sum[3:0];

  always_comb begin
    state_nx = state;
    cd_nx    = cd_cnt;
    id_nx    = id_q;
    lane_nx  = lane_q;
    last_nx  = last_grant;
    case (state)
      IDLE: begin
        if (grant) begin
          state_nx = ISSUE;
          id_nx    = win_id;
          lane_nx  = req_lane[win_id];
          last_nx  = win_id;
        end
      end
      ISSUE: begin
        if (game_over) begin
          state_nx = IDLE;
        end else if (tick) begin
          if (CD_NONE) begin
            state_nx = IDLE;
          end else begin
            state_nx = COOLDOWN;
            cd_nx    = CD_LOAD;
          end
        end
      end
      COOLDOWN: begin
        if (tick) begin
          if (cd_cnt <= CD_W'(1)) begin
            state_nx = IDLE;
            cd_nx    = '0;
          end else begin
            cd_nx = cd_cnt - CD_W'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign spawn_left_nx  = (state_nx == ISSUE && !lane_nx) ? (4'b0001 << id_nx) : 4'b0000;
  assign spawn_right_nx = (state_nx == ISSUE &&  lane_nx) ? (4'b0001 << id_nx) : 4'b0000;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state       <= IDLE;
      elixir      <= E_INIT;
      frame_cnt   <= '0;
      cd_cnt      <= '0;
      last_grant  <= 2'd3;
      id_q        <= 2'd0;
      lane_q      <= 1'b0;
      spawn_left  <= 4'b0000;
      spawn_right <= 4'b0000;
      busy        <= 1'b0;
    end else begin
      state       <= state_nx;
      elixir      <= elixir_nx;
      cd_cnt      <= cd_nx;
      last_grant  <= last_nx;
      id_q        <= id_nx;
      lane_q      <= lane_nx;
      spawn_left  <= spawn_left_nx;
      spawn_right <= spawn_right_nx;
      busy        <= (state_nx != IDLE);
      if (regen_step) frame_cnt <= regen_inc ? '0 : frame_cnt + FC_W'(1);
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_spawn_scheduler.sv
// Bench for spawn_scheduler: a default-parameter instance and a zero-cost,
// zero-cooldown instance, both checked every cycle against a frame-level model.
module tb_spawn_scheduler;

  localparam int EMAX = 10;
  localparam int FPE  = 60;
  localparam int M_COST [2][4] = '{'{3, 3, 2, 5}, '{0, 0, 0, 0}};
  localparam int M_CD   [2]    = '{30, 0};
  localparam int M_INIT [2]    = '{5, 10};

  logic       vga_clk = 1'b0;
  logic       reset   = 1'b1;
  logic       vsync   = 1'b0;
  int         phase   = 7;
  logic [3:0] rv [2];
  logic [3:0] rl [2];
  logic [3:0] ub [2];
  logic       go [2];
  logic [3:0] sl [2];
  logic [3:0] sr [2];
  logic [3:0] ack [2];
  logic [3:0] el [2];
  logic       bz [2];
  logic [1:0] dbg [2];

  int n_cmp = 0;
  int n_bad = 0;
  int rises = 0;

  // ---------------- clock / reset / frame generation ----------------
  always #5 vga_clk = ~vga_clk;

  // Eight clocks per frame, vsync high for the first two; phase 0 is the tick cycle.
  initial begin
    forever begin
      @(posedge vga_clk);
      #2;
      phase = (phase + 1) % 8;
      vsync = (phase < 2);
    end
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      rv[u] = 4'b0; rl[u] = 4'b0; ub[u] = 4'b0; go[u] = 1'b0;
    end
  end

  spawn_scheduler u_dut_a (
    .vga_clk(vga_clk), .reset(reset), .vsync(vsync), .game_over(go[0]),
    .req_valid(rv[0]), .req_lane(rl[0]), .unit_busy(ub[0]),
    .spawn_left(sl[0]), .spawn_right(sr[0]), .req_ack(ack[0]),
    .elixir(el[0]), .busy(bz[0]), .dbg_state(dbg[0])
  );

  spawn_scheduler #(
    .ELIXIR_INIT(10), .COST_AND(0), .COST_OR(0), .COST_NOT(0), .COST_NERD(0),
    .COOLDOWN_FRAMES(0)
  ) u_dut_b (
    .vga_clk(vga_clk), .reset(reset), .vsync(vsync), .game_over(go[1]),
    .req_valid(rv[1]), .req_lane(rl[1]), .unit_busy(ub[1]),
    .spawn_left(sl[1]), .spawn_right(sr[1]), .req_ack(ack[1]),
    .elixir(el[1]), .busy(bz[1]), .dbg_state(dbg[1])
  );

  // ---------------- behavioural model ----------------
  // phase: 0 waiting, 1 spawn level held, 2 cooling down
  int   m_el [2], m_fc [2], m_ph [2], m_cd [2], m_last [2], m_id [2];
  bit   m_lane [2];
  bit   vprev = 1'b0;
  bit   model_ok = 1'b0;

  function automatic int winner(input int u);
    int idx;
    if (reset || m_ph[u] != 0 || !(vsync && !vprev)) return -1;
    for (int k = 1; k <= 4; k++) begin
      idx = (m_last[u] + k) % 4;
      if (rv[u][idx] && !ub[u][idx] && m_el[u] >= M_COST[u][idx] && !go[u]) return idx;
    end
    return -1;
  endfunction

  always @(posedge vga_clk) begin
    bit t;
    t = vsync && !vprev;
    for (int u = 0; u < 2; u++) begin
      int w;
      int inc;
      w = winner(u);
      if (reset) begin
        m_el[u] = M_INIT[u]; m_fc[u] = 0; m_ph[u] = 0; m_cd[u] = 0;
        m_last[u] = 3; m_id[u] = 0; m_lane[u] = 1'b0;
      end else begin
        inc = 0;
        if (t && !go[u] && m_el[u] < EMAX) begin
          if (m_fc[u] == FPE - 1) begin m_fc[u] = 0; inc = 1; end
          else m_fc[u] = m_fc[u] + 1;
        end
        m_el[u] = m_el[u] + inc - ((w >= 0) ? M_COST[u][w] : 0);
        if (m_el[u] > EMAX) m_el[u] = EMAX;
        if (m_ph[u] == 0) begin
          if (w >= 0) begin
            m_ph[u] = 1; m_id[u] = w; m_lane[u] = rl[u][w]; m_last[u] = w;
          end
        end else if (m_ph[u] == 1) begin
          if (go[u]) m_ph[u] = 0;
          else if (t) begin
            if (M_CD[u] == 0) m_ph[u] = 0;
            else begin m_ph[u] = 2; m_cd[u] = M_CD[u]; end
          end
        end else if (t) begin
          m_cd[u] = m_cd[u] - 1;
          if (m_cd[u] == 0) m_ph[u] = 0;
        end
      end
    end
    vprev = vsync;
    if (reset) model_ok = 1'b1;
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge vga_clk) begin
    if (model_ok) begin
      for (int u = 0; u < 2; u++) begin
        int w;
        int e_sl;
        int e_sr;
        w    = winner(u);
        e_sl = (m_ph[u] == 1 && !m_lane[u]) ? (1 << m_id[u]) : 0;
        e_sr = (m_ph[u] == 1 &&  m_lane[u]) ? (1 << m_id[u]) : 0;
        chk($sformatf("req_ack[%0d]", u), int'(ack[u]), (w >= 0) ? (1 << w) : 0);
        chk($sformatf("spawn_left[%0d]", u), int'(sl[u]), e_sl);
        chk($sformatf("spawn_right[%0d]", u), int'(sr[u]), e_sr);
        chk($sformatf("elixir[%0d]", u), int'(el[u]), m_el[u]);
        chk($sformatf("busy[%0d]", u), int'(bz[u]), int'(m_ph[u] != 0));
      end
    end
  end

  always @(posedge vsync) if (sl[0][0]) rises++;

  // ---------------- driver tasks ----------------
  task automatic set_u(input int u, input logic [3:0] v, input logic [3:0] l,
                       input logic [3:0] b, input logic g);
    @(posedge vga_clk);
    #2;
    rv[u] = v; rl[u] = l; ub[u] = b; go[u] = g;
  endtask

  task automatic do_reset();
    @(posedge vga_clk);
    #2 reset = 1'b1;
    repeat (3) @(posedge vga_clk);
    #2 reset = 1'b0;
  endtask

  // Returns at the negedge inside the next tick cycle.
  task automatic goto_tick();
    do @(negedge vga_clk); while (phase != 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    do_reset();

    // Regen: 5 for 59 ticks, 6 at tick 60, saturates at 10 from tick 300.
    repeat (59) goto_tick();
    @(negedge vga_clk); chk("regen_t59", int'(el[0]), 5);
    goto_tick(); @(negedge vga_clk); chk("regen_t60", int'(el[0]), 6);
    repeat (239) goto_tick();
    @(negedge vga_clk); chk("regen_t299", int'(el[0]), 9);
    goto_tick(); @(negedge vga_clk); chk("regen_t300", int'(el[0]), 10);
    repeat (60) goto_tick();
    @(negedge vga_clk); chk("regen_sat", int'(el[0]), 10);

    // Single left spawn of unit 0 and its cooldown.
    set_u(0, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    do_reset();
    rises = 0;
    goto_tick(); chk("grant_ack", int'(ack[0]), 1);
    set_u(0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    @(negedge vga_clk);
    chk("grant_elixir", int'(el[0]), 2);
    chk("grant_left", int'(sl[0]), 1);
    goto_tick(); @(negedge vga_clk);
    chk("issue_end_left", int'(sl[0]), 0);
    chk("issue_end_busy", int'(bz[0]), 1);
    chk("vsync_rises", rises, 1);
    repeat (29) goto_tick();
    @(negedge vga_clk); chk("cooldown_29", int'(bz[0]), 1);
    goto_tick(); @(negedge vga_clk); chk("cooldown_30", int'(bz[0]), 0);

    // Round-robin on the zero-cost, zero-cooldown instance.
    set_u(1, 4'b1111, 4'b0000, 4'b0000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      logic [3:0] exp_ack;
      exp_ack = 4'b0001 << (k % 4);
      goto_tick(); chk($sformatf("rr_grant%0d", k), int'(ack[1]), int'(exp_ack));
      goto_tick(); chk($sformatf("rr_gap%0d", k), int'(ack[1]), 0);
    end
    chk("rr_elixir", int'(el[1]), 10);
    set_u(1, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Nerd waits for 5 elixir; granted the tick after regen reaches 5.
    set_u(0, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    do_reset();
    goto_tick(); chk("nerd_pre_ack", int'(ack[0]), 1);
    set_u(0, 4'b1000, 4'b0000, 4'b0000, 1'b0);
    repeat (178) goto_tick();
    @(negedge vga_clk); chk("nerd_t179_elixir", int'(el[0]), 4);
    goto_tick(); chk("nerd_t180_ack", int'(ack[0]), 0);
    @(negedge vga_clk); chk("nerd_t180_elixir", int'(el[0]), 5);
    goto_tick(); chk("nerd_t181_ack", int'(ack[0]), 8);
    @(negedge vga_clk); chk("nerd_t181_elixir", int'(el[0]), 0);

    // unit_busy masks a request until it clears.
    set_u(0, 4'b0100, 4'b0100, 4'b0100, 1'b0);
    do_reset();
    repeat (3) begin goto_tick(); chk("busy_masked_ack", int'(ack[0]), 0); end
    set_u(0, 4'b0100, 4'b0100, 4'b0000, 1'b0);
    goto_tick(); chk("busy_clear_ack", int'(ack[0]), 4);
    @(negedge vga_clk);
    chk("not_elixir", int'(el[0]), 3);
    chk("not_right", int'(sr[0]), 4);

    // game_over during the spawn level.
    set_u(0, 4'b0100, 4'b0100, 4'b0000, 1'b1);
    @(negedge vga_clk);
    @(negedge vga_clk);
    chk("go_right", int'(sr[0]), 0);
    chk("go_busy", int'(bz[0]), 0);
    set_u(0, 4'b1111, 4'b0000, 4'b0000, 1'b1);
    repeat (3) begin goto_tick(); chk("go_no_ack", int'(ack[0]), 0); end
    @(negedge vga_clk); chk("go_elixir", int'(el[0]), 3);

    // Reset in the middle of a cooldown.
    set_u(0, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    goto_tick(); chk("post_go_ack", int'(ack[0]), 1);
    set_u(0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    goto_tick();
    goto_tick();
    @(negedge vga_clk); chk("cd_busy", int'(bz[0]), 1);
    @(posedge vga_clk);
    #2 reset = 1'b1;
    @(posedge vga_clk);
    @(negedge vga_clk);
    chk("rst_elixir", int'(el[0]), 5);
    chk("rst_busy", int'(bz[0]), 0);
    chk("rst_spawn", int'(sl[0] | sr[0]), 0);
    chk("rst_ack", int'(ack[0]), 0);
    @(posedge vga_clk);
    #2 reset = 1'b0;
    repeat (4) @(negedge vga_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
